// File: rtl/store_buffer.sv
// store_buffer: posts core stores into a small FIFO and drains them over a
// handshaked data-memory bus. Loads are served by forwarding from the buffer
// or by a stalled bus read. StallM holds the core M stage while a load misses
// or the buffer is full.
// Optional feature macro: STORE_BUF_FWD_EN
//   defined     - loads matching a buffered store (word granular) are forwarded
//   not defined - any load waits for all stores to drain, then reads the bus
module store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              WrEn,
    input  logic              RdEn,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic [DATA_W-1:0] RData,
    output logic              StallM,
    output logic              Empty,
    output logic              BusReq,
    output logic              BusWE,
    output logic [ADDR_W-1:0] BusAddr,
    output logic [DATA_W-1:0] BusWData,
    input  logic              BusAck,
    input  logic [DATA_W-1:0] BusRData
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUS  = 2'd1,
        RD_BUS  = 2'd2,
        RD_DONE = 2'd3
    } stateT;

    stateT             state;
    logic [ADDR_W-1:0] entryAddr [DEPTH];
    logic [DATA_W-1:0] entryData [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  nextHead;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] rDataReg;

    logic wrAccept;
    logic storeFull;
    logic pop;
    logic loadHit;
    logic loadMiss;
    logic readGoIdle;
    logic readGoAck;

    // Store acceptance: fullness is judged on the registered count only
    always_comb begin
        wrAccept  = WrEn && !RdEn && (count <  CNT_W'(DEPTH));
        storeFull = WrEn && !RdEn && (count == CNT_W'(DEPTH));
        pop       = (state == WR_BUS) && BusAck;
        nextHead  = head + PTR_W'(1);
    end

`ifdef STORE_BUF_FWD_EN
    logic [DATA_W-1:0] fwdData;
    logic [PTR_W-1:0]  matchIdx;
    logic              anyMatch;

    // Word-granular match, scanned oldest to youngest so the youngest wins
    always_comb begin
        anyMatch = 1'b0;
        fwdData  = '0;
        matchIdx = head;
        for (int i = 0; i < int'(DEPTH); i++) begin
            matchIdx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) &&
                (entryAddr[matchIdx][ADDR_W-1:2] == Addr[ADDR_W-1:2])) begin
                anyMatch = 1'b1;
                fwdData  = entryData[matchIdx];
            end
        end
    end

    // Load classification and read-launch conditions with forwarding
    always_comb begin
        loadHit    = RdEn && anyMatch;
        loadMiss   = RdEn && !anyMatch;
        readGoIdle = loadMiss;
        readGoAck  = loadMiss;
    end

    assign RData = loadHit ? fwdData : rDataReg;
`else
    // Without forwarding every load reads the bus once the buffer is drained
    always_comb begin
        loadHit    = 1'b0;
        loadMiss   = RdEn;
        readGoIdle = RdEn && (count == CNT_W'(0));
        readGoAck  = RdEn && (count == CNT_W'(1));
    end

    assign RData = rDataReg;
`endif

    // Core hold: full buffer on a store, or a load waiting for bus data
    assign StallM = storeFull || (loadMiss && (state != RD_DONE) && !loadHit);

    // Nothing buffered and no bus transfer in flight
    assign Empty = (count == CNT_W'(0)) && (state == IDLE);

    // Entry storage; validity is tracked by head/count, so no reset needed
    always_ff @(posedge CLK) begin
        if (wrAccept) begin
            entryAddr[tail] <= Addr;
            entryData[tail] <= WData;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wrAccept) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= nextHead;
            end
            count <= count + CNT_W'(wrAccept) - CNT_W'(pop);
        end
    end

    // Bus sequencer with registered bus outputs and read data
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            BusReq   <= 1'b0;
            BusWE    <= 1'b0;
            BusAddr  <= '0;
            BusWData <= '0;
            rDataReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (readGoIdle) begin
                        state   <= RD_BUS;
                        BusReq  <= 1'b1;
                        BusWE   <= 1'b0;
                        BusAddr <= Addr;
                    end else if (count != CNT_W'(0)) begin
                        state    <= WR_BUS;
                        BusReq   <= 1'b1;
                        BusWE    <= 1'b1;
                        BusAddr  <= entryAddr[head];
                        BusWData <= entryData[head];
                    end else if (wrAccept) begin
                        // Empty buffer: launch the incoming store directly
                        state    <= WR_BUS;
                        BusReq   <= 1'b1;
                        BusWE    <= 1'b1;
                        BusAddr  <= Addr;
                        BusWData <= WData;
                    end
                end
                WR_BUS: begin
                    if (BusAck) begin
                        if (readGoAck) begin
                            state   <= RD_BUS;
                            BusWE   <= 1'b0;
                            BusAddr <= Addr;
                        end else if (count > CNT_W'(1)) begin
                            BusAddr  <= entryAddr[nextHead];
                            BusWData <= entryData[nextHead];
                        end else if (wrAccept) begin
                            // Store arriving as the last entry pops is next in line
                            BusAddr  <= Addr;
                            BusWData <= WData;
                        end else begin
                            state  <= IDLE;
                            BusReq <= 1'b0;
                        end
                    end
                end
                RD_BUS: begin
                    if (BusAck) begin
                        state    <= RD_DONE;
                        BusReq   <= 1'b0;
                        rDataReg <= BusRData;
                    end
                end
                RD_DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    BusReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer. Inputs are driven and
// outputs sampled around the falling clock edge.
module tb_store_buffer;

    logic        CLK;
    logic        Reset;
    logic        WrEn;
    logic        RdEn;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic [31:0] RData;
    logic        StallM;
    logic        Empty;
    logic        BusReq;
    logic        BusWE;
    logic [31:0] BusAddr;
    logic [31:0] BusWData;
    logic        BusAck;
    logic [31:0] BusRData;

    int nChecks;
    int nFails;

    store_buffer #(
        .DEPTH (4),
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .WrEn    (WrEn),
        .RdEn    (RdEn),
        .Addr    (Addr),
        .WData   (WData),
        .RData   (RData),
        .StallM  (StallM),
        .Empty   (Empty),
        .BusReq  (BusReq),
        .BusWE   (BusWE),
        .BusAddr (BusAddr),
        .BusWData(BusWData),
        .BusAck  (BusAck),
        .BusRData(BusRData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(negedge CLK);
    endtask

    task automatic setStore(input logic [31:0] a, input logic [31:0] d);
        WrEn = 1'b1; RdEn = 1'b0; Addr = a; WData = d;
    endtask

    task automatic setLoad(input logic [31:0] a);
        WrEn = 1'b0; RdEn = 1'b1; Addr = a;
    endtask

    task automatic setIdle();
        WrEn = 1'b0; RdEn = 1'b0;
    endtask

    task automatic checkWrite(input string tag, input logic [31:0] a);
        checkVal({tag, "_req"}, 32'(BusReq), 32'd1);
        checkVal({tag, "_we"}, 32'(BusWE), 32'd1);
        checkVal({tag, "_addr"}, BusAddr, a);
    endtask

    task automatic checkRead(input string tag, input logic [31:0] a);
        checkVal({tag, "_req"}, 32'(BusReq), 32'd1);
        checkVal({tag, "_we"}, 32'(BusWE), 32'd0);
        checkVal({tag, "_addr"}, BusAddr, a);
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        Reset = 1'b0; WrEn = 1'b0; RdEn = 1'b0; Addr = '0; WData = '0;
        BusAck = 1'b0; BusRData = '0;

        // Reset state
        nextCycle(); nextCycle();
        #1;
        checkVal("rst_stall", 32'(StallM), 32'd0);
        checkVal("rst_empty", 32'(Empty), 32'd1);
        checkVal("rst_busreq", 32'(BusReq), 32'd0);
        checkVal("rst_buswe", 32'(BusWE), 32'd0);
        checkVal("rst_busaddr", BusAddr, 32'd0);
        checkVal("rst_buswdata", BusWData, 32'd0);
        checkVal("rst_rdata", RData, 32'd0);
        nextCycle(); Reset = 1'b1;

        // 1: single store, ack two cycles after the request
        nextCycle(); setStore(32'h100, 32'hDEADBEEF); #1;
        checkVal("t1_stall", 32'(StallM), 32'd0);
        nextCycle(); setIdle(); #1;
        checkWrite("t1_wr", 32'h100);
        checkVal("t1_wdata", BusWData, 32'hDEADBEEF);
        checkVal("t1_notempty", 32'(Empty), 32'd0);
        nextCycle(); #1;
        checkWrite("t1_hold", 32'h100);
        nextCycle(); BusAck = 1'b1;
        nextCycle(); BusAck = 1'b0; #1;
        checkVal("t1_empty", 32'(Empty), 32'd1);
        checkVal("t1_reqdone", 32'(BusReq), 32'd0);

        // 2: fill to DEPTH, fifth store stalls, then drain in order
        for (int i = 0; i < 4; i++) begin
            nextCycle(); setStore(32'(i * 4), 32'(i + 1)); #1;
            checkVal($sformatf("t2_st%0d_stall", i), 32'(StallM), 32'd0);
        end
        nextCycle(); setStore(32'h10, 32'h5); BusAck = 1'b1; #1;
        checkVal("t2_full_stall", 32'(StallM), 32'd1);
        checkWrite("t2_d0", 32'h0);
        nextCycle(); #1;
        checkVal("t2_accept_stall", 32'(StallM), 32'd0);
        checkWrite("t2_d1", 32'h4);
        checkVal("t2_d1_data", BusWData, 32'h2);
        nextCycle(); setIdle(); #1;
        checkWrite("t2_d2", 32'h8);
        nextCycle(); #1;
        checkWrite("t2_d3", 32'hC);
        nextCycle(); #1;
        checkWrite("t2_d4", 32'h10);
        checkVal("t2_d4_data", BusWData, 32'h5);
        nextCycle(); BusAck = 1'b0; #1;
        checkVal("t2_empty", 32'(Empty), 32'd1);

`ifdef STORE_BUF_FWD_EN
        // 3: youngest matching store forwarded, no bus read
        nextCycle(); setStore(32'h200, 32'h11);
        nextCycle(); setStore(32'h200, 32'h22);
        nextCycle(); setLoad(32'h200); #1;
        checkVal("t3_rdata", RData, 32'h22);
        checkVal("t3_stall", 32'(StallM), 32'd0);
        checkWrite("t3_wr", 32'h200);
        checkVal("t3_wdata", BusWData, 32'h11);
        nextCycle(); setIdle(); BusAck = 1'b1; #1;
        checkWrite("t3_nord", 32'h200);
        nextCycle(); #1;
        checkVal("t3_wdata2", BusWData, 32'h22);
        nextCycle(); BusAck = 1'b0; #1;
        checkVal("t3_empty", 32'(Empty), 32'd1);
`endif

        // 4: load miss on empty buffer, ack three cycles later
        nextCycle(); setLoad(32'h300); #1;
        checkVal("t4_stall0", 32'(StallM), 32'd1);
        nextCycle(); #1;
        checkVal("t4_stall1", 32'(StallM), 32'd1);
        checkRead("t4_rd", 32'h300);
        nextCycle(); #1;
        checkVal("t4_stall2", 32'(StallM), 32'd1);
        nextCycle(); BusAck = 1'b1; BusRData = 32'h55; #1;
        checkVal("t4_stall3", 32'(StallM), 32'd1);
        nextCycle(); BusAck = 1'b0; BusRData = '0; #1;
        checkVal("t4_done_stall", 32'(StallM), 32'd0);
        checkVal("t4_rdata", RData, 32'h55);
        nextCycle(); setIdle(); #1;
        checkVal("t4_empty", 32'(Empty), 32'd1);

        // 5: load arrives while the first of two writes is in flight
        nextCycle(); setStore(32'h10, 32'hA1);
        nextCycle(); setStore(32'h14, 32'hA2);
        nextCycle(); setLoad(32'h400); #1;
        checkVal("t5_stall", 32'(StallM), 32'd1);
        checkWrite("t5_w0", 32'h10);
        nextCycle(); BusAck = 1'b1;
`ifdef STORE_BUF_FWD_EN
        nextCycle(); BusRData = 32'h77; #1;
        checkRead("t5_rd", 32'h400);
        checkVal("t5_rd_stall", 32'(StallM), 32'd1);
        nextCycle(); BusAck = 1'b0; BusRData = '0; #1;
        checkVal("t5_done_stall", 32'(StallM), 32'd0);
        checkVal("t5_rdata", RData, 32'h77);
        nextCycle(); setIdle(); #1;
        checkVal("t5_gap", 32'(BusReq), 32'd0);
        nextCycle(); BusAck = 1'b1; #1;
        checkWrite("t5_w1", 32'h14);
        nextCycle(); BusAck = 1'b0; #1;
        checkVal("t5_empty", 32'(Empty), 32'd1);
`else
        nextCycle(); #1;
        checkWrite("t5_w1", 32'h14);
        checkVal("t5_w1_stall", 32'(StallM), 32'd1);
        nextCycle(); BusRData = 32'h77; #1;
        checkRead("t5_rd", 32'h400);
        nextCycle(); BusAck = 1'b0; BusRData = '0; #1;
        checkVal("t5_done_stall", 32'(StallM), 32'd0);
        checkVal("t5_rdata", RData, 32'h77);
        nextCycle(); setIdle(); #1;
        checkVal("t5_empty", 32'(Empty), 32'd1);
`endif

        // 6: async reset mid-write with three entries queued
        nextCycle(); setStore(32'h20, 32'h1);
        nextCycle(); setStore(32'h24, 32'h2);
        nextCycle(); setStore(32'h28, 32'h3);
        nextCycle(); setIdle(); #1;
        checkWrite("t6_pre", 32'h20);
        checkVal("t6_pre_empty", 32'(Empty), 32'd0);
        #1 Reset = 1'b0;
        #1;
        checkVal("t6_req_drop", 32'(BusReq), 32'd0);
        checkVal("t6_empty", 32'(Empty), 32'd1);
        nextCycle(); Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nextCycle(); #1;
            checkVal($sformatf("t6_quiet%0d", i), 32'(BusReq), 32'd0);
        end
        checkVal("t6_empty_after", 32'(Empty), 32'd1);

        // 7: non-matching load drains the store, then reads the bus
        nextCycle(); setStore(32'h500, 32'h7);
        nextCycle(); setLoad(32'h504); BusAck = 1'b1; #1;
        checkVal("t7_stall", 32'(StallM), 32'd1);
        checkWrite("t7_wr", 32'h500);
        checkVal("t7_wdata", BusWData, 32'h7);
        nextCycle(); BusRData = 32'h99; #1;
        checkRead("t7_rd", 32'h504);
        checkVal("t7_rd_stall", 32'(StallM), 32'd1);
        nextCycle(); BusAck = 1'b0; BusRData = '0; #1;
        checkVal("t7_done_stall", 32'(StallM), 32'd0);
        checkVal("t7_rdata", RData, 32'h99);
        nextCycle(); setIdle(); #1;
        checkVal("t7_empty", 32'(Empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
